// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA widths, colour and requester constants, arbiter state type
package vga_pkg;
   localparam int X_W = 8;
   localparam int Y_W = 7;
   localparam int C_W = 12;
   localparam logic [11:0] COL_BLACK = 12'h000;
   localparam logic [11:0] COL_RED = 12'hF00;
   localparam int REQ_GREETING = 0;
   localparam int REQ_RENDER = 1;
   localparam int REQ_GAME_OVER = 2;
   localparam int REQ_SCORE = 3;
   typedef enum logic {ARB_IDLE, ARB_GRANTED} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: picks the next requester; round-robin from start, or lowest index when ARB_FIXED_PRIORITY_EN is defined
module rr_picker #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
`ifndef ARB_FIXED_PRIORITY_EN
   input  logic [$clog2(N)-1:0] start,
`endif
   output logic [$clog2(N)-1:0] winner,
   output logic                 any_req
);
   localparam int IW = $clog2(N);
   logic [IW-1:0] idx;
   // scan candidates from lowest to highest priority so the best hit is written last
   always_comb begin
      winner = '0;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
`ifdef ARB_FIXED_PRIORITY_EN
         idx = IW'(i);
`else
         idx = IW'((int'(start) + i) % N);
`endif
         if (req[idx]) winner = idx;
      end
   end
   assign any_req = |req;
endmodule

// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: burst-locked arbiter sharing the VGA write port; ARB_FIXED_PRIORITY_EN selects fixed priority
module vga_write_arbiter #(
   parameter int N_REQ = 4,
   parameter int X_W = vga_pkg::X_W,
   parameter int Y_W = vga_pkg::Y_W,
   parameter int C_W = vga_pkg::C_W,
   parameter int BURST_LIMIT = 256
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ-1:0]         req_last,
   input  logic [N_REQ*X_W-1:0]     req_x,
   input  logic [N_REQ*Y_W-1:0]     req_y,
   input  logic [N_REQ*C_W-1:0]     req_color,
   output logic [N_REQ-1:0]         req_ready,
   output logic [X_W-1:0]           vga_x,
   output logic [Y_W-1:0]           vga_y,
   output logic [C_W-1:0]           vga_color,
   output logic                     vga_plot,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     busy
);
   import vga_pkg::*;
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(BURST_LIMIT + 1);
   arb_state_t state, state_n;
   logic [IW-1:0] grant_n, winner;
   logic [CW-1:0] burst_cnt, cnt_n;
   logic any_req, xfer, rel;
`ifndef ARB_FIXED_PRIORITY_EN
   logic [IW-1:0] rr_ptr, rr_n;
`endif
   rr_picker #(.N(N_REQ)) u_pick (
      .req     (req_valid),
`ifndef ARB_FIXED_PRIORITY_EN
      .start   (rr_ptr),
`endif
      .winner  (winner),
      .any_req (any_req)
   );
   assign busy = (state == ARB_GRANTED);
   assign req_ready = busy ? N_REQ'(1) << grant_id : '0;
   assign xfer = busy & req_valid[grant_id];
   assign rel = xfer & (req_last[grant_id] | ((burst_cnt + CW'(1)) == CW'(BURST_LIMIT)));
   // next state: grant the picked source from idle, release on last pixel or burst limit
   always_comb begin
      state_n = state;
      grant_n = grant_id;
      cnt_n = burst_cnt;
`ifndef ARB_FIXED_PRIORITY_EN
      rr_n = rr_ptr;
`endif
      if (!busy) begin
         if (any_req) begin
            state_n = ARB_GRANTED;
            grant_n = winner;
            cnt_n = '0;
         end
      end else if (xfer) begin
         cnt_n = burst_cnt + CW'(1);
         if (rel) begin
            state_n = ARB_IDLE;
`ifndef ARB_FIXED_PRIORITY_EN
            rr_n = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + IW'(1);
`endif
         end
      end
   end
   // arbitration state registers
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= ARB_IDLE;
         grant_id <= '0;
         burst_cnt <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
         rr_ptr <= '0;
`endif
      end else begin
         state <= state_n;
         grant_id <= grant_n;
         burst_cnt <= cnt_n;
`ifndef ARB_FIXED_PRIORITY_EN
         rr_ptr <= rr_n;
`endif
      end
   end
   // output stage: register each accepted pixel and strobe plot for exactly one cycle
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         vga_x <= '0;
         vga_y <= '0;
         vga_color <= '0;
         vga_plot <= 1'b0;
      end else begin
         vga_plot <= xfer;
         if (xfer) begin
            vga_x <= req_x[int'(grant_id)*X_W +: X_W];
            vga_y <= req_y[int'(grant_id)*Y_W +: Y_W];
            vga_color <= req_color[int'(grant_id)*C_W +: C_W];
         end
      end
   end
endmodule

// File: tb/tb_vga_write_arbiter.sv
// tb_vga_write_arbiter: scoreboard bench; a burst-level model predicts every plot (source, pixel, cycle)
module tb_vga_write_arbiter;
   localparam int N = 4;
   localparam int LIM = 4;
   typedef struct {logic [7:0] x; logic [6:0] y; logic [11:0] c; bit last; int gap;} pix_t;
   typedef struct {int id; logic [7:0] x; logic [6:0] y; logic [11:0] c; bit endg; int cyc;} exp_t;
   logic clock = 1'b0;
   logic resetn = 1'b0;
   logic [N-1:0] req_valid = '0;
   logic [N-1:0] req_last = '0;
   logic [N*8-1:0] req_x = '0;
   logic [N*7-1:0] req_y = '0;
   logic [N*12-1:0] req_color = '0;
   logic [N-1:0] req_ready;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [11:0] vga_color;
   logic vga_plot, busy;
   logic [1:0] grant_id;
   pix_t st[N][$];
   pix_t q[N][$];
   exp_t eq[$];
   int hold[N];
   logic [N-1:0] fire = '0;
   bit flush = 0;
   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int ptr = 0;
   logic [26:0] last_out = '0;

   vga_write_arbiter #(.N_REQ(N), .X_W(8), .Y_W(7), .C_W(12), .BURST_LIMIT(LIM)) dut (
      .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_last(req_last),
      .req_x(req_x), .req_y(req_y), .req_color(req_color), .req_ready(req_ready),
      .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot),
      .grant_id(grant_id), .busy(busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // source drivers: present queue heads, pop on a handshake seen just before the edge
   initial begin
      for (int i = 0; i < N; i++) hold[i] = 0;
      forever begin
         @(negedge clock);
         if (flush) begin
            for (int i = 0; i < N; i++) begin
               q[i].delete();
               hold[i] = 0;
            end
            fire = '0;
            flush = 0;
         end
         for (int i = 0; i < N; i++) if (fire[i] && q[i].size() > 0) begin
            void'(q[i].pop_front());
            if (q[i].size() > 0) hold[i] = q[i][0].gap;
         end
         for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0 && hold[i] == 0) begin
               req_valid[i] = 1'b1;
               req_last[i] = q[i][0].last;
               req_x[i*8 +: 8] = q[i][0].x;
               req_y[i*7 +: 7] = q[i][0].y;
               req_color[i*12 +: 12] = q[i][0].c;
            end else begin
               req_valid[i] = 1'b0;
               req_last[i] = 1'($urandom);
               if (hold[i] > 0) hold[i]--;
            end
         end
         #4 fire = req_valid & req_ready;
      end
   end

   // monitor: compare every plot with the scoreboard, and check output hold between plots
   initial forever begin
      exp_t e;
      @(negedge clock);
      if (!resetn) continue;
      n_cmp++;
      if (!$onehot0(req_ready)) begin
         n_bad++;
         $display("FAIL ready_onehot: req_ready=%b, required one-hot or zero", req_ready);
      end
      if (vga_plot) begin
         n_cmp++;
         if (eq.size() == 0) begin
            n_bad++;
            $display("FAIL extra_plot: plot at cycle %0d x=%0d, required no plot", cyc, vga_x);
         end else begin
            e = eq.pop_front();
            if ({grant_id, vga_x, vga_y, vga_color, busy, cyc} !== {2'(e.id), e.x, e.y, e.c, !e.endg, e.cyc}) begin
               n_bad++;
               $display("FAIL plot: got id=%0d x=%0d y=%0d c=%h busy=%0d cyc=%0d, required id=%0d x=%0d y=%0d c=%h busy=%0d cyc=%0d",
                        grant_id, vga_x, vga_y, vga_color, busy, cyc, e.id, e.x, e.y, e.c, !e.endg, e.cyc);
            end
            last_out = {e.x, e.y, e.c};
         end
      end else begin
         n_cmp++;
         if ({vga_x, vga_y, vga_color} !== last_out) begin
            n_bad++;
            $display("FAIL data_hold: got %h, required %h", {vga_x, vga_y, vga_color}, last_out);
         end
         if (eq.size() > 0 && eq[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_plot: no plot by cycle %0d, required plot at cycle %0d", cyc, eq[0].cyc);
            void'(eq.pop_front());
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic stage(input int i, input logic [7:0] x, input logic [6:0] y, input logic [11:0] c, input bit last, input int gap);
      pix_t p;
      p.x = x;
      p.y = y;
      p.c = c;
      p.last = last;
      p.gap = gap;
      st[i].push_back(p);
   endtask

   // burst-level model: every idle cycle picks the first source with pending pixels in
   // priority order; the grant runs until its last pixel or LIM pixels, one plot per cycle
   task automatic predict(input int b);
      pix_t m[N][$];
      pix_t p;
      exp_t e;
      int t, w, k, j;
      t = b;
      for (int i = 0; i < N; i++) m[i] = q[i];
      forever begin
         w = -1;
         for (int i = N - 1; i >= 0; i--) begin
`ifdef ARB_FIXED_PRIORITY_EN
            j = i;
`else
            j = (ptr + i) % N;
`endif
            if (m[j].size() > 0) w = j;
         end
         if (w < 0) break;
         t++;
         k = 0;
         forever begin
            p = m[w].pop_front();
            k++;
            t += p.gap + 1;
            e.id = w;
            e.x = p.x;
            e.y = p.y;
            e.c = p.c;
            e.endg = p.last || k == LIM;
            e.cyc = t;
            eq.push_back(e);
            if (e.endg) break;
         end
         ptr = (w + 1) % N;
      end
   endtask

   task automatic start();
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
         q[i] = st[i];
         st[i].delete();
         hold[i] = 0;
      end
      predict(cyc);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((eq.size() > 0 || busy) && n < 3000) begin
         @(posedge clock);
         n++;
      end
      n_cmp++;
      if (eq.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d plots outstanding, required 0", eq.size());
         eq.delete();
         flush = 1;
      end
      repeat (2) @(posedge clock);
   endtask

   task automatic do_reset();
      @(posedge clock);
      #2 resetn = 1'b0;
      flush = 1;
      eq.delete();
      ptr = 0;
      last_out = '0;
      #1;
      check("rst_plot", 32'(vga_plot), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_grant", 32'(grant_id), 0);
      check("rst_x", 32'(vga_x), 0);
      check("rst_y", 32'(vga_y), 0);
      check("rst_color", 32'(vga_color), 0);
      repeat (2) @(posedge clock);
      #2 resetn = 1'b1;
   endtask

   initial begin
      int len, n;
      do_reset();
      for (int k = 0; k < 4; k++) stage(1, 8'(10 + k), 7'd20, 12'hF00, k == 3, 0);
      start();
      drain();
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < N; i++) repeat ($urandom_range(0, 3)) begin
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) stage(i, 8'($urandom), 7'($urandom), 12'($urandom), k == len - 1, 0);
         end
         start();
         drain();
      end
      for (int k = 0; k < 10; k++) stage(0, 8'(100 + k), 7'd5, 12'h0F0, k == 9, 0);
      for (int k = 0; k < 2; k++) stage(2, 8'(50 + k), 7'd9, 12'h00F, k == 1, 0);
      start();
      drain();
      for (int k = 0; k < 8; k++) stage(2, 8'(200 + k), 7'd33, 12'hABC, k == 7, 0);
      start();
      n = 0;
      while (eq.size() > 6 && n < 100) begin
         @(posedge clock);
         n++;
      end
      check("reset_wait", 32'(eq.size()), 6);
      do_reset();
      for (int k = 0; k < 4; k++) stage(0, 8'(30 + k), 7'd40, 12'h123, k == 3, (k == 2) ? 5 : 0);
      stage(3, 8'd77, 7'd77, 12'h777, 1, 0);
      start();
      drain();
      stage(0, 8'd1, 7'd1, 12'h001, 1, 0);
      stage(0, 8'd5, 7'd1, 12'h005, 1, 0);
      for (int i = 1; i < N; i++) stage(i, 8'(1 + i), 7'd1, 12'(i), 1, 0);
      start();
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
